// File: rtl/seq_pkg.sv
// Shared definitions for the program-counter sequencer: FSM state codes,
// instruction format/condition codes and instruction field helpers.
package seq_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_FETCH  = 3'd1;
    localparam state_t ST_DECODE = 3'd2;
    localparam state_t ST_EXEC   = 3'd3;
    localparam state_t ST_WAIT   = 3'd4;
    localparam state_t ST_HALT   = 3'd5;
    localparam state_t ST_PAUSE  = 3'd6;

    localparam logic [1:0] FMT_OP0    = 2'b00;
    localparam logic [1:0] FMT_OP1    = 2'b01;
    localparam logic [1:0] FMT_BRANCH = 2'b10;
    localparam logic [1:0] FMT_HALT   = 2'b11;

    localparam logic [1:0] COND_EQ0   = 2'b00;
    localparam logic [1:0] COND_EQ1   = 2'b01;
    localparam logic [1:0] COND_EQ2   = 2'b10;
    localparam logic [1:0] COND_NEVER = 2'b11;

    function automatic logic [1:0] ir_format(input logic [15:0] instr);
        return instr[1:0];
    endfunction

    function automatic logic [1:0] ir_cond(input logic [15:0] instr);
        return instr[3:2];
    endfunction

    function automatic logic [7:0] ir_offset(input logic [15:0] instr);
        return instr[11:4];
    endfunction

endpackage

// File: rtl/seq_cond.sv
// Combinational branch-condition evaluator: compares the condition register
// against the constant selected by the branch condition code.
module seq_cond
    import seq_pkg::*;
(
    input  logic [1:0]  condition,
    input  logic [15:0] creg,
    output logic        taken
);

    always_comb begin
        taken = 1'b0;
        case (condition)
            COND_EQ0:   taken = (creg == 16'h0000);
            COND_EQ1:   taken = (creg == 16'h0001);
            COND_EQ2:   taken = (creg == 16'h0002);
            COND_NEVER: taken = 1'b0;
            default:    taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Instruction sequencer: fetch, decode/branch, execute handshake and halt.
// Optional single-step PAUSE state and step port under `define SEQ_STEP_EN.
module pc_sequencer
    import seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
`ifdef SEQ_STEP_EN
    input  logic        step,
`endif
    output logic        mem_req,
    output logic [7:0]  mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    input  logic [15:0] creg,
    output logic        exec_start,
    input  logic        exec_done,
    output logic [15:0] ir,
    output logic [7:0]  pc,
    output logic        busy,
    output logic        halted,
    output state_t      o_dbg_state
);

    // Fetch handshake: mem_req stays high with mem_addr stable until the
    // cycle mem_ack is seen high; that cycle transfers mem_rdata into ir.

    state_t      r_state;
    logic [7:0]  r_pc;
    logic [15:0] r_ir;

    logic        w_taken;
    logic [1:0]  w_fmt;
    logic [7:0]  w_pc_inc;
    state_t      w_end_state;

    assign w_fmt    = ir_format(r_ir);
    assign w_pc_inc = r_pc + 8'd1;

    seq_cond u_cond (
        .condition (ir_cond(r_ir)),
        .creg      (creg),
        .taken     (w_taken)
    );

`ifdef SEQ_STEP_EN
    assign w_end_state = run ? ST_PAUSE : ST_IDLE;
`else
    assign w_end_state = run ? ST_FETCH : ST_IDLE;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_pc    <= 8'h00;
            r_ir    <= 16'h0000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (run) r_state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (mem_ack) begin
                        r_ir    <= mem_rdata;
                        r_state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    case (w_fmt)
                        FMT_BRANCH: begin
                            r_pc    <= w_taken ? ir_offset(r_ir) : w_pc_inc;
                            r_state <= w_end_state;
                        end
                        FMT_HALT: r_state <= ST_HALT;
                        default:  r_state <= ST_EXEC;
                    endcase
                end
                ST_EXEC: r_state <= ST_WAIT;
                ST_WAIT: begin
                    if (exec_done) begin
                        r_pc    <= w_pc_inc;
                        r_state <= w_end_state;
                    end
                end
                ST_HALT: begin
                    if (!run) r_state <= ST_IDLE;
                end
`ifdef SEQ_STEP_EN
                // Stopping wins over stepping when both are requested.
                ST_PAUSE: begin
                    if (!run)      r_state <= ST_IDLE;
                    else if (step) r_state <= ST_FETCH;
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign mem_req     = (r_state == ST_FETCH);
    assign mem_addr    = r_pc;
    assign exec_start  = (r_state == ST_EXEC);
    assign ir          = r_ir;
    assign pc          = r_pc;
    assign busy        = (r_state != ST_IDLE) && (r_state != ST_HALT) &&
                         (r_state != ST_PAUSE);
    assign halted      = (r_state == ST_HALT);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a table of single-instruction
// vectors plus hand-written sequences for run-drop and mid-instruction reset.
module tb_pc_sequencer;
    import seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = 16'h0000;
    logic [15:0] creg = 16'h0000;
    logic        exec_start;
    logic        exec_done = 1'b0;
    logic [15:0] ir;
    logic [7:0]  pc;
    logic        busy;
    logic        halted;
    state_t      dbg_state;
`ifdef SEQ_STEP_EN
    logic        step = 1'b1;
`endif

    int n_checks = 0;
    int n_errors = 0;

    pc_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
`ifdef SEQ_STEP_EN
        .step        (step),
`endif
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .creg        (creg),
        .exec_start  (exec_start),
        .exec_done   (exec_done),
        .ir          (ir),
        .pc          (pc),
        .busy        (busy),
        .halted      (halted),
        .o_dbg_state (dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fetch(input int budget);
        int n;
        n = 0;
        while (mem_req !== 1'b1 && n < budget) begin
            step_clk();
            n++;
        end
        check("mem_req_wait", {31'd0, mem_req}, 32'd1);
    endtask

    // kind: 0 = execute instruction, 1 = branch, 2 = halt
    typedef struct {
        logic [15:0] instr;
        logic [15:0] creg;
        int          done_lat;
        int          kind;
        logic [7:0]  exp_pc;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs[NVEC];

    initial begin
        logic [7:0] exp_addr;
        int pulses;

        vecs[0] = '{16'h0000, 16'h0000, 3, 0, 8'h01};
        vecs[1] = '{16'h0052, 16'h0000, 0, 1, 8'h05};
        vecs[2] = '{16'h0052, 16'h0003, 0, 1, 8'h06};
        vecs[3] = '{16'h0206, 16'h0001, 0, 1, 8'h20};
        vecs[4] = '{16'h030A, 16'h0001, 0, 1, 8'h21};
        vecs[5] = '{16'h0FFE, 16'h0000, 0, 1, 8'h22};
        vecs[6] = '{16'h0FFA, 16'h0002, 0, 1, 8'hFF};
        vecs[7] = '{16'h0001, 16'h0000, 1, 0, 8'h00};
        vecs[8] = '{16'h0012, 16'h0005, 0, 1, 8'h01};
        vecs[9] = '{16'h0003, 16'h0000, 0, 2, 8'h01};

        // reset state
        step_clk();
        step_clk();
        rst = 1'b0;
        check("rst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
        check("rst_pc", {24'd0, pc}, 32'h0);
        check("rst_ir", {16'd0, ir}, 32'h0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_exec_start", {31'd0, exec_start}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);

        step_clk();
        check("idle_hold", {29'd0, dbg_state}, {29'd0, ST_IDLE});

        // table-driven instruction stream
        run = 1'b1;
        exp_addr = 8'h00;
        for (int i = 0; i < NVEC; i++) begin
            wait_fetch(20);
            check($sformatf("v%0d_mem_addr", i), {24'd0, mem_addr}, {24'd0, exp_addr});
            check($sformatf("v%0d_busy_fetch", i), {31'd0, busy}, 32'd1);
            mem_rdata = vecs[i].instr;
            creg      = vecs[i].creg;
            mem_ack   = 1'b1;
            step_clk();
            mem_ack   = 1'b0;
            mem_rdata = 16'hDEAD;
            check($sformatf("v%0d_ir", i), {16'd0, ir}, {16'd0, vecs[i].instr});
            step_clk();
            creg = 16'hAAAA;
            if (vecs[i].kind == 0) begin
                pulses = int'(exec_start);
                check($sformatf("v%0d_busy_exec", i), {31'd0, busy}, 32'd1);
                step_clk();
                pulses += int'(exec_start);
                for (int c = 0; c < vecs[i].done_lat; c++) begin
                    step_clk();
                    pulses += int'(exec_start);
                end
                check($sformatf("v%0d_pc_wait", i), {24'd0, pc}, {24'd0, exp_addr});
                exec_done = 1'b1;
                step_clk();
                exec_done = 1'b0;
                check($sformatf("v%0d_exec_pulses", i), pulses, 32'd1);
            end
            check($sformatf("v%0d_pc", i), {24'd0, pc}, {24'd0, vecs[i].exp_pc});
            check($sformatf("v%0d_halted", i), {31'd0, halted},
                  (vecs[i].kind == 2) ? 32'd1 : 32'd0);
            exp_addr = vecs[i].exp_pc;
        end

        // halt held while run=1, then run=0 returns to IDLE
        step_clk();
        check("halt_busy", {31'd0, busy}, 32'd0);
        check("halt_state", {29'd0, dbg_state}, {29'd0, ST_HALT});
        check("halt_pc", {24'd0, pc}, 32'h01);
        run = 1'b0;
        step_clk();
        check("halt_exit_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
        check("halt_exit_halted", {31'd0, halted}, 32'd0);
        check("halt_exit_busy", {31'd0, busy}, 32'd0);

        // run dropped during WAIT: instruction completes, then IDLE
        rst = 1'b1;
        step_clk();
        rst = 1'b0;
        run = 1'b1;
        wait_fetch(5);
        mem_rdata = 16'h0000;
        mem_ack   = 1'b1;
        step_clk();
        mem_ack = 1'b0;
        step_clk();
        check("drop_exec_start", {31'd0, exec_start}, 32'd1);
        step_clk();
        run = 1'b0;
        step_clk();
        step_clk();
        check("drop_wait_state", {29'd0, dbg_state}, {29'd0, ST_WAIT});
        exec_done = 1'b1;
        step_clk();
        exec_done = 1'b0;
        check("drop_pc", {24'd0, pc}, 32'h01);
        check("drop_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
        for (int c = 0; c < 3; c++) begin
            check("drop_no_req", {31'd0, mem_req}, 32'd0);
            step_clk();
        end

        // exec_done outside WAIT is ignored
        exec_done = 1'b1;
        step_clk();
        exec_done = 1'b0;
        check("done_idle_pc", {24'd0, pc}, 32'h01);

        // reset mid-FETCH with a simultaneous ack
        run = 1'b1;
        step_clk();
        check("mf_req", {31'd0, mem_req}, 32'd1);
        check("mf_addr", {24'd0, mem_addr}, 32'h01);
        rst       = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 16'h1234;
        step_clk();
        rst     = 1'b0;
        mem_ack = 1'b0;
        check("mf_rst_req", {31'd0, mem_req}, 32'd0);
        check("mf_rst_pc", {24'd0, pc}, 32'h00);
        check("mf_rst_ir", {16'd0, ir}, 32'h0);
        check("mf_rst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});

        // reset during WAIT with a simultaneous done
        wait_fetch(5);
        mem_rdata = 16'h0001;
        mem_ack   = 1'b1;
        step_clk();
        mem_ack = 1'b0;
        step_clk();
        step_clk();
        rst       = 1'b1;
        exec_done = 1'b1;
        step_clk();
        rst       = 1'b0;
        exec_done = 1'b0;
        run       = 1'b0;
        check("mw_rst_pc", {24'd0, pc}, 32'h00);
        check("mw_rst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
        check("mw_rst_busy", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
